// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: Execute/Memory/Writeback hazard sources in,
// forwarding selects, stall/flush controls and event counters out.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic [4:0]           Rs1E;
    logic [4:0]           Rs2E;
    logic [4:0]           RdE;
    logic [1:0]           ResultSrcE;
    logic [1:0]           PCSrcE;
    logic                 MulStartE;
    logic [4:0]           RdM;
    logic [4:0]           RdW;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 CntClr;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushM;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 MulBusy;
    logic                 MulDoneE;
    logic [CNT_WIDTH-1:0] StallCount;
    logic [CNT_WIDTH-1:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
        output ResultSrcE, PCSrcE, MulStartE,
        output RdM, RdW, RegWriteM, RegWriteW, CntClr,
        input  StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE,
        input  MulBusy, MulDoneE,
        input  StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
        input  ResultSrcE, PCSrcE, MulStartE,
        input  RdM, RdW, RegWriteM, RegWriteW, CntClr,
        output StallF, StallD, StallE,
        output FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE,
        output MulBusy, MulDoneE,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard control: forwarding, load-use and branch
// handling, multi-cycle Execute sequencing and saturating event counters.
module hazard_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 0) ? $clog2(MUL_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_mul_stall;
    logic                 w_done;
    logic                 w_lw_stall;
    logic                 w_stall_f;
    logic                 w_stall_d;
    logic                 w_stall_e;
    logic                 w_flush_d;
    logic                 w_flush_e;
    logic                 w_flush_m;
    logic [CNT_WIDTH-1:0] r_scnt;
    logic [CNT_WIDTH-1:0] r_fcnt;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] rd_m,
        input logic       rw_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && rd_m != 5'd0 && rd_m == src) begin
            sel = 2'b10;
        end else if (rw_w && rd_w != 5'd0 && rd_w == src) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM,
                                   bus.RegWriteW, bus.RdW);
    assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM,
                                   bus.RegWriteW, bus.RdW);

    assign w_lw_stall = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A start seen while reset is held must not stall the pipeline.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mul_stall = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.MulStartE && rst) begin
                    w_mul_stall = 1'b1;
                    w_cnt_nxt   = CW'(MUL_CYCLES - 3);
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_mul_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_m = 1'b0;
        if (!rst) begin
            w_stall_f = 1'b0;
        end else if (w_mul_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
        end else if (bus.PCSrcE != 2'b00) begin
            // Redirect discards the Decode instruction, so no load-use hold.
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    assign bus.StallF   = w_stall_f;
    assign bus.StallD   = w_stall_d;
    assign bus.StallE   = w_stall_e;
    assign bus.FlushD   = w_flush_d;
    assign bus.FlushE   = w_flush_e;
    assign bus.FlushM   = w_flush_m;
    assign bus.MulBusy  = (r_state != S_IDLE);
    assign bus.MulDoneE = w_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scnt <= '0;
            r_fcnt <= '0;
        end else if (bus.CntClr) begin
            r_scnt <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_stall_f && r_scnt != '1) begin
                r_scnt <= r_scnt + 1'b1;
            end
            if (w_flush_d && r_fcnt != '1) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign bus.StallCount = r_scnt;
    assign bus.FlushCount = r_fcnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random
// traffic, checked against a cycle-position reference model.
module tb_hazard_ctrl;
    localparam int MULC = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc, pcsrc;
        logic       mul, rwm, rww, clr;
    } stim_t;

    typedef struct packed {
        logic [5:0] hz;
        logic [3:0] fwd;
        logic [1:0] mul;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   m_pos  = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;

    hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    hazard_ctrl #(
        .WIDTH(32),
        .MUL_CYCLES(MULC),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk();
        stim_t s;
        s.rst_n = 1'b1;
        s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0;
        s.rde = 0; s.rdm = 0; s.rdw = 0;
        s.rsrc = 0; s.pcsrc = 0;
        s.mul = 0; s.rwm = 0; s.rww = 0; s.clr = 0;
        return s;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src,
                                       input stim_t s);
        if (s.rwm && s.rdm != 0 && s.rdm == src) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic lw, ms, in_rst;
        @(posedge clk);
        #1;
        rst = s.rst_n;
        bus.Rs1D = s.rs1d; bus.Rs2D = s.rs2d;
        bus.Rs1E = s.rs1e; bus.Rs2E = s.rs2e;
        bus.RdE = s.rde; bus.RdM = s.rdm; bus.RdW = s.rdw;
        bus.ResultSrcE = s.rsrc; bus.PCSrcE = s.pcsrc;
        bus.MulStartE = s.mul; bus.RegWriteM = s.rwm;
        bus.RegWriteW = s.rww; bus.CntClr = s.clr;
        in_rst = !s.rst_n;
        if (in_rst) begin
            m_pos = 0; m_scnt = 0; m_fcnt = 0;
        end
        e.fwd = {fwd(s.rs1e, s), fwd(s.rs2e, s)};
        lw = (s.rsrc == 2'b01) && (s.rde != 0) &&
             (s.rde == s.rs1d || s.rde == s.rs2d);
        ms = !in_rst && ((m_pos == 0 && s.mul) ||
                         (m_pos >= 1 && m_pos <= MULC - 2));
        e.mul = {m_pos != 0, m_pos == MULC - 1};
        if (in_rst)              e.hz = 6'b000_000;
        else if (ms)             e.hz = 6'b111_001;
        else if (s.pcsrc != 0)   e.hz = 6'b000_110;
        else if (lw)             e.hz = 6'b110_010;
        else                     e.hz = 6'b000_000;
        e.cnt = {4'(m_scnt), 4'(m_fcnt)};
        q.push_back(e);
        if (!in_rst) begin
            if (s.clr) begin
                m_scnt = 0; m_fcnt = 0;
            end else begin
                if (e.hz[5] && m_scnt < CMAX) m_scnt++;
                if (e.hz[2] && m_fcnt < CMAX) m_fcnt++;
            end
        end
        if (in_rst)                m_pos = 0;
        else if (m_pos == 0)       m_pos = s.mul ? 1 : 0;
        else if (m_pos == MULC - 1) m_pos = 0;
        else                       m_pos++;
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [5:0] ahz;
        logic [3:0] afwd;
        logic [1:0] amul;
        logic [7:0] acnt;
        if (q.size() != 0) begin
            e = q.pop_front();
            ahz = {bus.StallF, bus.StallD, bus.StallE,
                   bus.FlushD, bus.FlushE, bus.FlushM};
            afwd = {bus.ForwardAE, bus.ForwardBE};
            amul = {bus.MulBusy, bus.MulDoneE};
            acnt = {bus.StallCount, bus.FlushCount};
            checks += 4;
            if (ahz !== e.hz) begin
                errors++;
                $display("FAIL stall_flush t=%0t got=%b exp=%b",
                         $time, ahz, e.hz);
            end
            if (afwd !== e.fwd) begin
                errors++;
                $display("FAIL forward t=%0t got=%b exp=%b",
                         $time, afwd, e.fwd);
            end
            if (amul !== e.mul) begin
                errors++;
                $display("FAIL mul_busy_done t=%0t got=%b exp=%b",
                         $time, amul, e.mul);
            end
            if (acnt !== e.cnt) begin
                errors++;
                $display("FAIL counters t=%0t got=%h exp=%h",
                         $time, acnt, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
        bus.ResultSrcE = 0; bus.PCSrcE = 0; bus.MulStartE = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0; bus.CntClr = 0;

        s = mk(); s.rst_n = 0;
        drive(s); drive(s);

        s = mk(); s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5;
        drive(s);
        s.rdm = 0; drive(s);
        s.rs1e = 0; s.rdw = 0; drive(s);

        s = mk(); s.rsrc = 1; s.rde = 7; s.rs2d = 7; drive(s);
        s.rde = 0; drive(s);

        s = mk(); s.rsrc = 1; s.rde = 7; s.rs2d = 7; s.pcsrc = 1;
        drive(s);
        drive(mk());

        s = mk(); s.mul = 1; s.rsrc = 1; s.rde = 7; s.rs1d = 7;
        for (int i = 0; i < 4; i++) drive(s);
        drive(mk()); drive(mk());

        s = mk(); s.mul = 1;
        for (int i = 0; i < 8; i++) drive(s);
        drive(mk());

        s = mk(); s.mul = 1; drive(s);
        s = mk(); s.rst_n = 0; drive(s);
        drive(mk()); drive(mk());

        s = mk(); s.rsrc = 1; s.rde = 3; s.rs1d = 3;
        for (int i = 0; i < 20; i++) drive(s);
        s = mk(); s.clr = 1; drive(s);
        drive(mk());

        for (int i = 0; i < 400; i++) begin
            s = mk();
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.rs1d = 5'($urandom_range(0, 3));
            s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e = 5'($urandom_range(0, 3));
            s.rs2e = 5'($urandom_range(0, 3));
            s.rde = 5'($urandom_range(0, 3));
            s.rdm = 5'($urandom_range(0, 3));
            s.rdw = 5'($urandom_range(0, 3));
            s.rsrc = 2'($urandom_range(0, 3));
            s.pcsrc = ($urandom_range(0, 5) == 0) ?
                      2'($urandom_range(1, 3)) : 2'b00;
            s.mul = ($urandom_range(0, 7) == 0);
            s.rwm = 1'($urandom_range(0, 1));
            s.rww = 1'($urandom_range(0, 1));
            s.clr = ($urandom_range(0, 29) == 0);
            drive(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
